// File: rtl/pipe_pkg.sv
// Shared definitions for the P7 pipeline control slice.
//   md_start_e  : E-stage multiply/divide start codes
//   T_W         : width of the Tuse/Tnew timing fields
//   TUSE_NONE   : Tuse value meaning "operand never read"
//   EXC_VECTOR  : exception entry address, also used by the pipeline registers
//   src_hazard  : RAW check of one D-stage source against the E and M producers
package pipe_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_RSVD = 2'd3
  } md_start_e;

  localparam int unsigned    T_W        = 2;
  localparam logic [T_W-1:0] TUSE_NONE  = 2'd3;
  localparam logic [31:0]    EXC_VECTOR = 32'h0000_4180;

  // A producer only forces a stall if its result becomes forwardable later
  // than the consumer needs it. Tnew never exceeds 3, so Tuse=TUSE_NONE
  // can never stall. $zero is hard-wired and never a hazard.
  function automatic logic src_hazard(
    input logic [4:0]     src,
    input logic [T_W-1:0] tuse,
    input logic [4:0]     e_a3,
    input logic [T_W-1:0] e_tnew,
    input logic [4:0]     m_a3,
    input logic [T_W-1:0] m_tnew
  );
    return (src != 5'd0) &&
           (((e_a3 == src) && (e_tnew > tuse)) ||
            ((m_a3 == src) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer.
//   clk, reset : clock, synchronous active-high reset
//   req        : exception request; blocks new starts, counting continues
//   start      : E-stage MD start code (md_start_e)
//   busy       : MDU occupied (counter non-zero)
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] start,
  output logic       busy
);

  logic [CNT_W-1:0] busy_cnt;

  // An operation already in flight always completes, even across an
  // exception; only the launch of a new one is suppressed by req.
  // A start while busy is illegal and simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (req) begin
      if (busy_cnt != '0) busy_cnt <= busy_cnt - CNT_W'(1);
    end else if (start == MD_MULT && busy_cnt == '0) begin
      busy_cnt <= CNT_W'(MULT_CYCLES);
    end else if (start == MD_DIV && busy_cnt == '0) begin
      busy_cnt <= CNT_W'(DIV_CYCLES);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

  assign busy = (busy_cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and stall scheduler for the five-stage P7 pipeline.
//   clk, reset                 : clock, synchronous active-high reset
//   D_rs/D_rt, D_Tuse_rs/_rt   : D-stage sources and their Tuse
//   E_A3/M_A3, E_Tnew/M_Tnew   : E/M destinations and their Tnew
//   D_is_md, E_md_start        : MDU users in D, MD start in E
//   D_eret, E/M_mtc0_epc       : eret vs pending EPC writes
//   Req                        : exception request, overrides all stalls
//   F_enable, D_enable         : pipeline register enables
//   E_freeze                   : bubble insert into E
//   md_busy                    : MDU occupied
//   stall_cnt                  : stalled-cycle performance counter
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     D_rs,
  input  logic [4:0]     D_rt,
  input  logic [T_W-1:0] D_Tuse_rs,
  input  logic [T_W-1:0] D_Tuse_rt,
  input  logic [4:0]     E_A3,
  input  logic [4:0]     M_A3,
  input  logic [T_W-1:0] E_Tnew,
  input  logic [T_W-1:0] M_Tnew,
  input  logic           D_is_md,
  input  logic [1:0]     E_md_start,
  input  logic           D_eret,
  input  logic           E_mtc0_epc,
  input  logic           M_mtc0_epc,
  input  logic           Req,
  output logic           F_enable,
  output logic           D_enable,
  output logic           E_freeze,
  output logic           md_busy,
  output logic [31:0]    stall_cnt
);

  logic stall_rs, stall_rt, stall_md, stall_eret, stall;
  logic md_starting;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .req   (Req),
    .start (E_md_start),
    .busy  (md_busy)
  );

  assign stall_rs = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
  assign stall_rt = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);

  // A start sitting in E makes the MDU busy from the next edge, so a D-stage
  // MD instruction must already wait this cycle. Reserved code is no start.
  assign md_starting = (E_md_start == MD_MULT) || (E_md_start == MD_DIV);
  assign stall_md    = D_is_md && (md_busy || md_starting);

  // eret must read the EPC value written by an older mtc0.
  assign stall_eret  = D_eret && (E_mtc0_epc || M_mtc0_epc);

  // Req wins so the flush to the exception vector is never held off.
  assign stall = (stall_rs || stall_rt || stall_md || stall_eret) && !Req;

  assign F_enable = !stall;
  assign D_enable = !stall;
  assign E_freeze = stall;

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule
